// File: rtl/nrs_gold_seq_gen.sv
// NRS Gold sequence generator: loads c_init, runs the NC-step warm-up, then streams c(n) over valid/ready.
// Optional macro GOLD_PAIR_OUT_EN: emit {c(2m+1), c(2m)} per beat and advance both LFSRs two steps per beat.
module nrs_gold_seq_gen #(
    parameter int CINIT_W = 31,
    parameter int NC      = 1600,
    parameter int LEN_W   = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [CINIT_W-1:0] cinit,
    input  logic [LEN_W-1:0]   num_bits,
    input  logic               out_ready,
    output logic               out_valid,
`ifdef GOLD_PAIR_OUT_EN
    output logic [1:0]         out_bit,
`else
    output logic               out_bit,
`endif
    output logic               busy,
    output logic               done,
    output logic [1:0]         dbg_state
);

    // Handshake: a beat transfers on a rising clk edge where out_valid && out_ready;
    // while out_valid is high and out_ready low, out_bit and the sequence position hold.

    localparam int WW = (NC > 0) ? $clog2(NC + 1) : 1;
    localparam logic [WW-1:0] WC_LAST = WW'((NC > 0) ? NC - 1 : 0);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WARMUP = 2'd1,
        S_RUN    = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [30:0]       x1_q, x2_q;
    logic [LEN_W-1:0]  rem_q;
    logic [WW-1:0]     wcnt_q;
    logic              vld_q;
    logic              fire;

    function automatic logic [30:0] x1_step(input logic [30:0] x);
        return {x[3] ^ x[0], x[30:1]};
    endfunction

    function automatic logic [30:0] x2_step(input logic [30:0] x);
        return {x[3] ^ x[2] ^ x[1] ^ x[0], x[30:1]};
    endfunction

    assign fire = vld_q & out_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = (NC > 0) ? S_WARMUP : S_RUN;
                end
            end
            S_WARMUP: begin
                if (wcnt_q == WC_LAST) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (rem_q == '0) begin
                    state_d = S_DONE;
                end else if (fire && rem_q == LEN_W'(1)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        busy      = (state_q != S_IDLE);
        done      = (state_q == S_DONE);
        dbg_state = state_q;
    end

    // out_valid is registered: the first RUN cycle primes it, which gives the NC+1 start latency.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            x1_q   <= '0;
            x2_q   <= '0;
            rem_q  <= '0;
            wcnt_q <= '0;
            vld_q  <= 1'b0;
        end else begin
            vld_q <= (state_q == S_RUN) && (state_d == S_RUN);
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        x1_q   <= 31'h1;
                        x2_q   <= 31'(cinit);
                        rem_q  <= num_bits;
                        wcnt_q <= '0;
                    end
                end
                S_WARMUP: begin
                    x1_q   <= x1_step(x1_q);
                    x2_q   <= x2_step(x2_q);
                    wcnt_q <= wcnt_q + WW'(1);
                end
                S_RUN: begin
                    if (fire) begin
`ifdef GOLD_PAIR_OUT_EN
                        x1_q <= x1_step(x1_step(x1_q));
                        x2_q <= x2_step(x2_step(x2_q));
`else
                        x1_q <= x1_step(x1_q);
                        x2_q <= x2_step(x2_q);
`endif
                        rem_q <= rem_q - LEN_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign out_valid = vld_q;

`ifdef GOLD_PAIR_OUT_EN
    assign out_bit = vld_q ? {x1_q[1] ^ x2_q[1], x1_q[0] ^ x2_q[0]} : 2'b00;
`else
    assign out_bit = vld_q ? (x1_q[0] ^ x2_q[0]) : 1'b0;
`endif

endmodule

// File: tb/tb_nrs_gold_seq_gen.sv
// Bench for nrs_gold_seq_gen: three instances (NC = 0, 1600, 4) checked against a software Gold model.
// Honours GOLD_PAIR_OUT_EN the same way as the design.
module tb_nrs_gold_seq_gen;

`ifdef GOLD_PAIR_OUT_EN
    localparam int PW = 2;
`else
    localparam int PW = 1;
`endif

    // clock / reset
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    logic [2:0]          start_r, rdy_r, vld_w, busy_w, done_w;
    logic [2:0][30:0]    cinit_r;
    logic [2:0][7:0]     nb_r;
    logic [2:0][PW-1:0]  bit_w;
    logic [2:0][1:0]     st_w;

    nrs_gold_seq_gen #(.CINIT_W(31), .NC(0), .LEN_W(8)) u_nc0 (
        .clk(clk), .rst(rst), .start(start_r[0]), .cinit(cinit_r[0]), .num_bits(nb_r[0]),
        .out_ready(rdy_r[0]), .out_valid(vld_w[0]), .out_bit(bit_w[0]), .busy(busy_w[0]),
        .done(done_w[0]), .dbg_state(st_w[0])
    );

    nrs_gold_seq_gen #(.CINIT_W(31), .NC(1600), .LEN_W(8)) u_nc1600 (
        .clk(clk), .rst(rst), .start(start_r[1]), .cinit(cinit_r[1]), .num_bits(nb_r[1]),
        .out_ready(rdy_r[1]), .out_valid(vld_w[1]), .out_bit(bit_w[1]), .busy(busy_w[1]),
        .done(done_w[1]), .dbg_state(st_w[1])
    );

    nrs_gold_seq_gen #(.CINIT_W(31), .NC(4), .LEN_W(8)) u_nc4 (
        .clk(clk), .rst(rst), .start(start_r[2]), .cinit(cinit_r[2]), .num_bits(nb_r[2]),
        .out_ready(rdy_r[2]), .out_valid(vld_w[2]), .out_bit(bit_w[2]), .busy(busy_w[2]),
        .done(done_w[2]), .dbg_state(st_w[2])
    );

    // scoreboard
    logic [PW-1:0] exp_q[$];
    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    endtask

    // reference model: x sequences as plain bit arrays from their recurrences
    bit x1a[0:2399];
    bit x2a[0:2399];

    function automatic void build_exp(input logic [30:0] ci, input int nc, input int nb);
        logic [PW-1:0] beat;
        exp_q.delete();
        for (int i = 0; i < 31; i++) begin
            x1a[i] = (i == 0);
            x2a[i] = ci[i];
        end
        for (int m = 31; m < nc + nb * PW + 31; m++) begin
            x1a[m] = x1a[m-28] ^ x1a[m-31];
            x2a[m] = x2a[m-28] ^ x2a[m-29] ^ x2a[m-30] ^ x2a[m-31];
        end
        for (int m = 0; m < nb; m++) begin
            for (int j = 0; j < PW; j++) begin
                beat[j] = x1a[nc + PW * m + j] ^ x2a[nc + PW * m + j];
            end
            exp_q.push_back(beat);
        end
    endfunction

    // driver + monitor for one request on instance idx
    task automatic run_seq(input int idx, input int nc, input logic [30:0] ci, input int nb,
                           input bit rnd, input int inj1, input int inj2, input int abort_at,
                           input bit start_in_done);
        int t, acc, limit;
        bit seen, held, fin, rdy;
        logic [PW-1:0] held_bit, e;
        build_exp(ci, nc, nb);
        cinit_r[idx] = ci;
        nb_r[idx]    = 8'(nb);
        start_r[idx] = 1'b1;
        rdy_r[idx]   = 1'b0;
        @(negedge clk);
        start_r[idx] = 1'b0;
        check("busy_after_start", busy_w[idx], 1);
        t = 0; acc = 0; seen = 0; held = 0; fin = 0;
        limit = nc + 4 * nb + 50;
        while (!fin) begin
            if (t > limit) begin
                check("timeout", t, limit);
                fin = 1;
            end else begin
                if (held) begin
                    check("stall_valid", vld_w[idx], 1);
                    check("stall_bit", bit_w[idx], held_bit);
                end
                if (vld_w[idx] && !seen) begin
                    seen = 1;
                    check("first_valid_latency", t, nc + 1);
                end
                if (done_w[idx]) begin
                    check("done_no_valid", vld_w[idx], 0);
                    check("done_beats", acc, nb);
                    if (!rnd) check("done_latency", t, nc + 1 + nb);
                    if (nb == 0) check("no_valid_seen", seen, 0);
                    if (start_in_done) begin
                        cinit_r[idx] = ~ci;
                        start_r[idx] = 1'b1;
                    end
                    @(negedge clk);
                    start_r[idx] = 1'b0;
                    check("busy_after_done", busy_w[idx], 0);
                    check("done_one_cycle", done_w[idx], 0);
                    check("exp_left", exp_q.size(), 0);
                    fin = 1;
                end else begin
                    rdy = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
                    rdy_r[idx] = rdy;
                    held = vld_w[idx] && !rdy;
                    if (held) held_bit = bit_w[idx];
                    if (vld_w[idx] && rdy) begin
                        if (exp_q.size() == 0) begin
                            check("extra_beat", 1, 0);
                        end else begin
                            e = exp_q.pop_front();
                            check("beat", bit_w[idx], e);
                        end
                        acc++;
                    end
                    if (t == inj1 || t == inj2) begin
                        cinit_r[idx] = ~ci;
                        nb_r[idx]    = 8'd3;
                        start_r[idx] = 1'b1;
                    end
                    if (abort_at >= 0 && acc == abort_at) begin
                        @(posedge clk);
                        #2 rst = 1'b0;
                        #1;
                        check("abort_valid", vld_w[idx], 0);
                        check("abort_bit", bit_w[idx], 0);
                        check("abort_busy", busy_w[idx], 0);
                        check("abort_done", done_w[idx], 0);
                        check("abort_state", st_w[idx], 0);
                        @(negedge clk);
                        rst = 1'b1;
                        start_r[idx] = 1'b0;
                        exp_q.delete();
                        fin = 1;
                    end else begin
                        @(negedge clk);
                        start_r[idx] = 1'b0;
                        t++;
                    end
                end
            end
        end
        rdy_r[idx] = 1'b0;
    endtask

    initial begin
        logic [30:0] ci;
        rst     = 1'b0;
        start_r = '0;
        rdy_r   = '0;
        cinit_r = '0;
        nb_r    = '0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            check("rst_valid", vld_w[i], 0);
            check("rst_bit", bit_w[i], 0);
            check("rst_busy", busy_w[i], 0);
            check("rst_done", done_w[i], 0);
            check("rst_state", st_w[i], 0);
        end
        rst = 1'b1;
        @(negedge clk);

        run_seq(0, 0, 31'h0, (PW == 2) ? 16 : 32, 0, -1, -1, -1, 0);
        run_seq(0, 0, 31'h1, 32, 0, -1, -1, -1, 1);
        run_seq(1, 1600, 31'h12345, 200, 1, 500, 1700, -1, 1);
        run_seq(1, 1600, 31'h7654321, 20, 1, -1, -1, -1, 0);

        ci = 31'($urandom);
        run_seq(0, 0, ci, 40, 1, -1, -1, 10, 0);
        repeat (2) @(negedge clk);
        run_seq(0, 0, ci, 40, 1, -1, -1, -1, 0);

        run_seq(2, 4, 31'($urandom), 0, 0, -1, -1, -1, 0);
        for (int k = 0; k < 4; k++) begin
            run_seq(2, 4, 31'($urandom), int'($urandom_range(1, 50)), 1, 2, -1, -1, 1);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/nrs_gold_seq_gen.md
Name: nrs_gold_seq_gen

Overview:
- Downstream consumer of the NRS c_init computation in the NRS value generator.
- Loads a 31-bit c_init and builds the length-31 Gold sequence c(n) = x1(n+NC) ^ x2(n+NC).
- Runs the NC-step warm-up, then streams pseudo-random bits through a valid/ready handshake to the NRS QPSK mapper.

Parameters:
- CINIT_W, 31, width of c_init input; x1/x2 LFSR length is fixed at 31.
- NC, 1600, warm-up steps discarded before the first output bit; 0 is legal.
- LEN_W, 8, width of the requested-bit count.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request; samples cinit and num_bits; honoured only in IDLE.
- cinit  in  CINIT_W  x2 initial state; bit i = x2(i).
- num_bits  in  LEN_W  number of output beats to produce.
- out_ready  in  1  consumer accepts the current beat.
- out_valid  out  1  out_bit is valid.
- out_bit  out  1  c(n) (2 bits wide when GOLD_PAIR_OUT_EN is defined, see below).
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse after the last beat is accepted.

Behaviour:
- Reset (rst=0, async): state=IDLE; x1=0; x2=0; counters=0; out_valid=0; out_bit=0; busy=0; done=0. Reset mid-operation aborts the sequence immediately; no done pulse.
- LFSR registers: bit0 holds x(n), bit30 holds x(n+30).
- Step operation: shift right by one.
  - x1 new bit30 = x1[3]^x1[0].
  - x2 new bit30 = x2[3]^x2[2]^x2[1]^x2[0].
- out_bit = x1[0]^x2[0], driven from registered state and gated to 0 when out_valid=0.
- IDLE:
  - On start: x1 = 31'h1, x2 = cinit, rem = num_bits, wcnt = 0.
  - Next state is WARMUP if NC>0, else RUN.
  - start while busy is ignored; no effect on state or registers.
- WARMUP: step both LFSRs every cycle and increment wcnt. After NC steps (wcnt==NC-1 on the stepping cycle), go to RUN.
- RUN:
  - out_valid = (rem != 0).
  - On out_valid & out_ready: step both LFSRs and decrement rem. If rem was 1, go to DONE.
  - out_valid & !out_ready: hold LFSRs, out_bit and rem stable; no step.
  - rem == 0 on entry (num_bits = 0): go to DONE next cycle with no beat issued.
- DONE: done=1 for exactly one cycle, busy=1, out_valid=0; then IDLE. A start in this cycle is ignored.
- Latency: start sampled at edge k → out_valid first high after edge k+NC+1.
  - Back-to-back accepts give one bit per cycle.
  - busy falls 1 cycle after done.
- Warm-up counter width is $clog2(NC+1), minimum 1.

Optional Feature:
- Macro: GOLD_PAIR_OUT_EN.
- Defined:
  - out_bit is 2 bits: [0] = c(2m), [1] = c(2m+1), one QPSK symbol per beat.
  - Each accepted beat advances both LFSRs by two steps in one cycle (unrolled feedback; new bit29 and bit30 per step rules).
  - num_bits counts pairs.
  - Warm-up still takes NC cycles at one step per cycle.
- Undefined: out_bit is 1 bit and there is a single step per beat, as above.

Test Plan:
- NC=0, cinit=0, num_bits=32, out_ready=1 → out_valid from cycle 1 after start for 32 cycles; bits = 1, then thirty 0s, then 1; done pulses once; busy falls next cycle.
- NC=0, cinit=1, num_bits=32 → all 32 bits 0 (x1 and x2 terms cancel at n=0 and n=31).
- NC=1600, cinit=31'h12345, num_bits=200, out_ready toggled pseudo-randomly → first out_valid exactly 1601 cycles after start; out_bit stable while stalled; the 200 bits match the bench's software Gold model.
- start pulsed during WARMUP and RUN with different cinit → ignored; sequence matches the first cinit; second start after busy=0 is accepted.
- rst asserted mid-RUN after 10 beats → outputs return to reset values asynchronously; no done; a fresh start reproduces the sequence from c(0).
- num_bits=0 with NC=4 → busy for 4 WARMUP cycles plus 1 RUN cycle, out_valid never high, then done pulse.
- GOLD_PAIR_OUT_EN, NC=0, cinit=0, num_bits=16 → first beat 2'b01 ({c(1),c(0)}), beats 2–15 are 2'b00, beat 16 is 2'b10 (c(31)=1).
